// File: rtl/tb_uart_pkg.sv
// -----------------------------------------------------------------------------
// tb_uart_pkg
//   Shared types and helpers for the UART receiver and its FIFO.
//   - rx_state_e : receiver FSM states
//   - parity_e   : parity mode encoding (matches the PARITY parameter values)
//   - rx_evt_t   : per-cycle frame outcome produced by the receiver FSM
//   - clks_per_bit() : clock cycles per serial bit (truncated division)
// -----------------------------------------------------------------------------
package tb_uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PAR       = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } rx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    // Outcome of the last stop-bit sample; at most one bit is ever set.
    typedef struct packed {
        logic push;
        logic frame_err;
        logic parity_err;
    } rx_evt_t;

    function automatic int unsigned clks_per_bit(input int unsigned freq,
                                                 input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Generic first-word-fall-through synchronous FIFO.
//   Ports:
//     clk_i, rst_ni      : clock, asynchronous active-low reset
//     push_i, data_i     : write request and data
//     pop_i              : read request (ignored when empty)
//     data_o             : head entry, valid whenever empty_o is low (0 when empty)
//     full_o, empty_o    : status
//     count_o            : occupancy, 0..DEPTH
//   A push while full is accepted only if a pop happens in the same cycle;
//   otherwise it is discarded and the contents are untouched.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("tb_uart_rx_fifo: DEPTH must be a power of two >= 2");
    end

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wr_ptr_q;
    logic [AW-1:0]               rd_ptr_q;
    logic [AW:0]                 count_q;
    logic                        do_push;
    logic                        do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    // Full + simultaneous pop frees the slot being written this cycle.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; data_o is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Parametrised UART receiver with error detection and a buffered
//   valid/ready output.
//   Ports:
//     clk_i, rst_ni   : clock, asynchronous active-low reset
//     rx_i            : serial line (idle high, asynchronous to clk_i)
//     data_o, valid_o : head-of-FIFO word and FIFO non-empty
//     ready_i         : consumer accepts data_o when valid_o & ready_i
//     count_o         : FIFO occupancy
//     frame_err_o     : one-cycle pulse, a stop bit sampled low
//     parity_err_o    : one-cycle pulse, parity mismatch (stop bits good)
//     overflow_o      : sticky, a good frame was dropped on a full FIFO
//     clr_i           : synchronous clear of overflow_o (a new drop wins)
// -----------------------------------------------------------------------------
module tb_uart_rx
    import tb_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD        = 256_000,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          rx_i,
    output logic [DATA_BITS-1:0]          data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          overflow_o,
    input  logic                          clr_i
);

    localparam int unsigned CPB      = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int unsigned CW       = $clog2(CPB);
    localparam int unsigned IW       = $clog2(DATA_BITS);
    localparam parity_e     PAR_MODE = parity_e'(PARITY[1:0]);
    localparam bit          PAR_EN   = (PAR_MODE != PAR_NONE);

    if (CPB < 4) begin : g_chk_cpb
        $error("tb_uart_rx: CLK_FREQ_HZ/BAUD must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
        $error("tb_uart_rx: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_chk_par
        $error("tb_uart_rx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("tb_uart_rx: STOP_BITS must be 1 or 2");
    end

    // ---------------- input synchroniser (resets to idle-high) --------------
    logic [1:0] sync_q;
    logic       rx_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], rx_i};
    end
    assign rx_s = sync_q[1];

    // ---------------- FSM and datapath state --------------------------------
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;
    logic                 sidx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bad_q;
    logic                 stop_bad_q;
    rx_evt_t              evt;

    logic tick;
    logic last_data;
    logic last_stop;
    logic stop_fail;
    logic par_exp;

    assign tick      = (cnt_q == '0);
    assign last_data = (idx_q == IW'(DATA_BITS - 1));
    assign last_stop = (sidx_q == 1'(STOP_BITS - 1));
    // Includes the sample being taken right now on the final stop bit.
    assign stop_fail = stop_bad_q | ~rx_s;
    // Even: parity bit equals XOR of data; odd: its inverse.
    assign par_exp   = (^shift_q) ^ (PAR_MODE == PAR_ODD);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= RX_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:      if (!rx_s) state_d = RX_START;
            RX_START:     if (tick)  state_d = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:      if (tick && last_data) state_d = PAR_EN ? RX_PAR : RX_STOP;
            RX_PAR:       if (tick)  state_d = RX_STOP;
            RX_STOP:      if (tick && last_stop)
                              state_d = stop_fail ? RX_WAIT_IDLE : RX_IDLE;
            RX_WAIT_IDLE: if (rx_s)  state_d = RX_IDLE;
            default:      state_d = RX_IDLE;
        endcase
    end

    // Output logic: frame outcome on the last stop-bit sample.
    // Frame error takes priority over parity error.
    always_comb begin
        evt = '0;
        if (state_q == RX_STOP && tick && last_stop) begin
            if (stop_fail)      evt.frame_err  = 1'b1;
            else if (par_bad_q) evt.parity_err = 1'b1;
            else                evt.push       = 1'b1;
        end
    end

    // Bit timing, shift register and per-frame error tracking
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            sidx_q     <= 1'b0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    // Half a bit to land in the middle of the start bit.
                    if (!rx_s) cnt_q <= CW'(CPB / 2 - 1);
                end
                RX_START: begin
                    if (tick) begin
                        cnt_q      <= CW'(CPB - 1);
                        idx_q      <= '0;
                        sidx_q     <= 1'b0;
                        par_bad_q  <= 1'b0;
                        stop_bad_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        // LSB first: after DATA_BITS shifts bit 0 sits at [0].
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        idx_q   <= idx_q + IW'(1);
                        cnt_q   <= CW'(CPB - 1);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RX_PAR: begin
                    if (tick) begin
                        par_bad_q <= rx_s ^ par_exp;
                        cnt_q     <= CW'(CPB - 1);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (!rx_s) stop_bad_q <= 1'b1;
                        sidx_q <= sidx_q + 1'b1;
                        cnt_q  <= CW'(CPB - 1);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- receive buffer and status -----------------------------
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic drop;

    assign pop     = ready_i & ~fifo_empty;
    assign valid_o = ~fifo_empty;
    assign drop    = evt.push & fifo_full & ~pop;

    tb_uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (evt.push),
        .data_i  (shift_q),
        .pop_i   (pop),
        .data_o  (data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            frame_err_o  <= evt.frame_err;
            parity_err_o <= evt.parity_err;
            overflow_o   <= drop | (overflow_o & ~clr_i);
        end
    end

endmodule

// File: tb/tb_tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_tb_uart_rx
//   Scoreboard bench for tb_uart_rx at 10 clocks/bit with three instances:
//     A: 8N1, FIFO_DEPTH=4   B: 8E1, FIFO_DEPTH=16   C: 7O2, FIFO_DEPTH=16
//   Stimulus queues expected events (data / frame error / parity error);
//   a monitor pops and compares whenever an instance presents one.
// -----------------------------------------------------------------------------
module tb_tb_uart_rx;

    localparam int CPB     = 10;
    localparam int EV_DATA = 0;
    localparam int EV_FERR = 1;
    localparam int EV_PERR = 2;

    typedef struct {
        int kind;
        int data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1;
    logic clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;

    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic       valid_a, valid_b, valid_c;
    logic [2:0] count_a;
    logic [4:0] count_b, count_c;
    logic       ferr_a, ferr_b, ferr_c;
    logic       perr_a, perr_b, perr_c;
    logic       ovf_a, ovf_b, ovf_c;

    int checks = 0;
    int failures = 0;
    ev_t q_a[$];
    ev_t q_b[$];
    ev_t q_c[$];

    always #5 clk = ~clk;

    tb_uart_rx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_a), .data_o(data_a),
        .valid_o(valid_a), .ready_i(rdy_a), .count_o(count_a),
        .frame_err_o(ferr_a), .parity_err_o(perr_a), .overflow_o(ovf_a),
        .clr_i(clr_a));

    tb_uart_rx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_b), .data_o(data_b),
        .valid_o(valid_b), .ready_i(rdy_b), .count_o(count_b),
        .frame_err_o(ferr_b), .parity_err_o(perr_b), .overflow_o(ovf_b),
        .clr_i(clr_b));

    tb_uart_rx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(7),
                 .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_c), .data_o(data_c),
        .valid_o(valid_c), .ready_i(rdy_c), .count_o(count_c),
        .frame_err_o(ferr_c), .parity_err_o(perr_c), .overflow_o(ovf_c),
        .clr_i(clr_c));

    // ---------------- helpers ------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int d, input int kind, input int data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        case (d)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic observe(input int d, input int kind, input int data);
        ev_t e;
        bit  have;
        have = 1'b0;
        case (d)
            0:       if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
            1:       if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
            default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
            failures++;
            $display("FAIL dut%0d unexpected event: got kind=%0d data=%0h, expected none",
                     d, kind, data);
        end else if (e.kind != kind || e.data != data) begin
            failures++;
            $display("FAIL dut%0d event: got kind=%0d data=%0h, expected kind=%0d data=%0h",
                     d, kind, data, e.kind, e.data);
        end
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        if (valid_a && rdy_a) observe(0, EV_DATA, int'(data_a));
        if (ferr_a)           observe(0, EV_FERR, 0);
        if (perr_a)           observe(0, EV_PERR, 0);
        if (valid_b && rdy_b) observe(1, EV_DATA, int'(data_b));
        if (ferr_b)           observe(1, EV_FERR, 0);
        if (perr_b)           observe(1, EV_PERR, 0);
        if (valid_c && rdy_c) observe(2, EV_DATA, int'(data_c));
        if (ferr_c)           observe(2, EV_FERR, 0);
        if (perr_c)           observe(2, EV_PERR, 0);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v);
        case (d)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // Sends n bits LSB first, optionally holds the line low, then idles high.
    task automatic send(input int d, input logic [15:0] bits, input int n, input int hold_low);
        for (int i = 0; i < n; i++) begin
            drive(d, bits[i]);
            idle(CPB);
        end
        if (hold_low > 0) begin
            drive(d, 1'b0);
            idle(hold_low);
        end
        drive(d, 1'b1);
    endtask

    function automatic logic [15:0] frame8(input logic [7:0] d, input logic stop);
        return {6'h3f, stop, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame_p(input logic [7:0] d, input logic p, input logic stop);
        return {5'h1f, stop, p, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame_c(input logic [6:0] d, input logic p,
                                            input logic s1, input logic s2);
        return {5'h1f, s2, s1, p, d, 1'b0};
    endfunction

    // ---------------- stimulus ----------------------------------------------
    initial begin
        rst_n = 1'b0;
        idle(3);
        chk("rst valid_a", 32'(valid_a), 0);
        chk("rst count_a", 32'(count_a), 0);
        chk("rst data_a", 32'(data_a), 0);
        chk("rst ferr_a", 32'(ferr_a), 0);
        chk("rst ovf_a", 32'(ovf_a), 0);
        rst_n = 1'b1;
        idle(5);

        // 8N1 basic byte
        expect_ev(0, EV_DATA, 'hA5);
        send(0, frame8(8'hA5, 1'b1), 10, 0);
        idle(20);
        chk("a5 drained", 32'(q_a.size()), 0);
        chk("a5 count_a", 32'(count_a), 0);

        // Even parity: wrong then right, then both errors, then good again
        expect_ev(1, EV_PERR, 0);
        send(1, frame_p(8'h07, 1'b0, 1'b1), 11, 0);
        idle(20);
        chk("perr drained", 32'(q_b.size()), 0);
        chk("perr valid_b", 32'(valid_b), 0);
        expect_ev(1, EV_DATA, 'h07);
        send(1, frame_p(8'h07, 1'b1, 1'b1), 11, 0);
        idle(20);
        chk("par07 drained", 32'(q_b.size()), 0);
        expect_ev(1, EV_FERR, 0);
        send(1, frame_p(8'h07, 1'b0, 1'b0), 11, 0);
        idle(20);
        chk("both err drained", 32'(q_b.size()), 0);
        expect_ev(1, EV_DATA, 'hE1);
        send(1, frame_p(8'hE1, 1'b0, 1'b1), 11, 0);
        idle(20);
        chk("parE1 drained", 32'(q_b.size()), 0);

        // Odd parity, two stop bits
        expect_ev(2, EV_DATA, 'h55);
        send(2, frame_c(7'h55, 1'b1, 1'b1, 1'b1), 11, 0);
        idle(20);
        chk("c55 drained", 32'(q_c.size()), 0);
        expect_ev(2, EV_FERR, 0);
        send(2, frame_c(7'h55, 1'b1, 1'b1, 1'b0), 11, 0);
        idle(20);
        chk("c stop2 drained", 32'(q_c.size()), 0);
        expect_ev(2, EV_PERR, 0);
        send(2, frame_c(7'h55, 1'b0, 1'b1, 1'b1), 11, 0);
        idle(20);
        chk("c odd perr drained", 32'(q_c.size()), 0);

        // Frame error with line held low, then recovery
        expect_ev(0, EV_FERR, 0);
        send(0, frame8(8'h3C, 1'b0), 10, 50);
        idle(5);
        chk("ferr drained", 32'(q_a.size()), 0);
        chk("ferr count_a", 32'(count_a), 0);
        expect_ev(0, EV_DATA, 'h11);
        send(0, frame8(8'h11, 1'b1), 10, 0);
        idle(20);
        chk("11 drained", 32'(q_a.size()), 0);

        // Short glitch on idle line
        drive(0, 1'b0);
        idle(3);
        drive(0, 1'b1);
        idle(30);
        chk("glitch valid_a", 32'(valid_a), 0);
        chk("glitch count_a", 32'(count_a), 0);
        expect_ev(0, EV_DATA, 'hC3);
        send(0, frame8(8'hC3, 1'b1), 10, 0);
        idle(20);
        chk("c3 drained", 32'(q_a.size()), 0);

        // Overflow on depth-4 FIFO
        rdy_a = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) expect_ev(0, EV_DATA, i);
            send(0, frame8(8'(i), 1'b1), 10, 0);
        end
        idle(5);
        chk("ovf count_a", 32'(count_a), 4);
        chk("ovf flag", 32'(ovf_a), 1);
        chk("ovf head", 32'(data_a), 1);
        rdy_a = 1'b1;
        idle(10);
        chk("ovf pops drained", 32'(q_a.size()), 0);
        chk("ovf count after pop", 32'(count_a), 0);
        chk("ovf sticky", 32'(ovf_a), 1);
        clr_a = 1'b1;
        idle(1);
        clr_a = 1'b0;
        chk("ovf cleared", 32'(ovf_a), 0);

        // Reset mid-frame
        rdy_a = 1'b0;
        send(0, frame8(8'h33, 1'b1), 10, 0);
        idle(5);
        chk("pre-rst count_a", 32'(count_a), 1);
        fork
            send(0, frame8(8'hFF, 1'b1), 10, 0);
            begin
                idle(40);
                rst_n = 1'b0;
                #2;
                chk("mid rst valid_a", 32'(valid_a), 0);
                chk("mid rst count_a", 32'(count_a), 0);
                chk("mid rst data_a", 32'(data_a), 0);
                chk("mid rst ferr_a", 32'(ferr_a), 0);
                chk("mid rst perr_a", 32'(perr_a), 0);
                idle(3);
                rst_n = 1'b1;
            end
        join
        rdy_a = 1'b1;
        idle(20);
        chk("post rst valid_a", 32'(valid_a), 0);
        expect_ev(0, EV_DATA, 'h5A);
        send(0, frame8(8'h5A, 1'b1), 10, 0);
        idle(20);
        chk("5a drained", 32'(q_a.size()), 0);
        chk("final q_b", 32'(q_b.size()), 0);
        chk("final q_c", 32'(q_c.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500_000;
        failures++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
